// File: rtl/m_pcpi_pkg.sv
// m_pcpi_pkg: shared FSM states, M-extension opcode fields and decode helper for the PCPI initiator
package m_pcpi_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  function automatic logic is_m_insn(input logic [31:0] insn);
    return insn[6:0] == OPCODE_OP && insn[31:25] == FUNCT7_MULDIV;
  endfunction
endpackage

// File: rtl/m_pcpi_if.sv
// m_pcpi_if: core request/response channel plus PCPI bus between pipeline, initiator and responder
// master: initiator view (takes req_*, resp_ready, pcpi_wr/rd/wait/ready; drives the rest)
// slave : core + responder view (the opposite directions)
interface m_pcpi_if #(parameter int LAT_W = 16) ();
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_insn;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_wr;
  logic [31:0]      resp_rd;
  logic             resp_trap;
  logic [LAT_W-1:0] resp_cycles;
  logic             pcpi_valid;
  logic [31:0]      pcpi_insn;
  logic [31:0]      pcpi_rs1;
  logic [31:0]      pcpi_rs2;
  logic             pcpi_wr;
  logic [31:0]      pcpi_rd;
  logic             pcpi_wait;
  logic             pcpi_ready;
  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2, resp_ready,
           pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output req_ready, resp_valid, resp_wr, resp_rd, resp_trap, resp_cycles,
           pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
  );
  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2, resp_ready,
           pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  req_ready, resp_valid, resp_wr, resp_rd, resp_trap, resp_cycles,
           pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
  );
endinterface

// File: rtl/m_pcpi_watchdog.sv
// m_pcpi_watchdog: no-response timer for one PCPI request
// start_i/clear_i reset the timer; tick_i marks an ISSUE cycle without pcpi_ready;
// wait_i (pcpi_wait) disarms it for the rest of the request; expired_o fires on the
// cycle the count reaches TIMEOUT_CYCLES.
module m_pcpi_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic tick_i,
  input  logic wait_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  always_comb begin
    cnt_d = cnt_q;
    busy_d = busy_q;
    if (start_i || clear_i) begin
      cnt_d = '0;
      busy_d = 1'b0;
    end else if (tick_i) begin
      busy_d = busy_q | wait_i;
      cnt_d = (wait_i || busy_q) ? cnt_q : cnt_q + CW'(1);
    end
  end
  // Expiry is judged on the pre-increment count so the trap lands on the TIMEOUT_CYCLES-th tick.
  assign expired_o = tick_i && !wait_i && !busy_q && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/m_pcpi_initiator.sv
// m_pcpi_initiator: core-side PCPI initiator; issues one request, waits for ready/timeout, returns rd/wr/trap
// Ports: clk, reset (async active-high), bus (m_pcpi_if.master) carrying the core
// req/resp channel and the PCPI bus. One request outstanding at a time.
module m_pcpi_initiator
  import m_pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int FILTER_M = 0,
  parameter int LAT_W = 16
) (
  input logic clk,
  input logic reset,
  m_pcpi_if.master bus
);
  state_e state_q, state_d;
  logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic wr_q, wr_d, trap_q, trap_d;
  logic [LAT_W-1:0] cyc_q, cyc_d;
  logic accept, wd_tick, wd_clear, wd_expired;
  assign accept = state_q == IDLE && bus.req_valid;
  assign wd_tick = state_q == ISSUE && !bus.pcpi_ready;
  assign wd_clear = state_q == RESP && bus.resp_ready;
  m_pcpi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk(clk),
    .reset(reset),
    .start_i(accept),
    .tick_i(wd_tick),
    .wait_i(bus.pcpi_wait),
    .clear_i(wd_clear),
    .expired_o(wd_expired)
  );
  always_comb begin
    state_d = state_q;
    insn_d = insn_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rd_d = rd_q;
    wr_d = wr_q;
    trap_d = trap_q;
    cyc_d = cyc_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        insn_d = bus.req_insn;
        rs1_d = bus.req_rs1;
        rs2_d = bus.req_rs2;
        rd_d = '0;
        wr_d = 1'b0;
        cyc_d = '0;
        // Filtered instructions never reach the bus: trap straight into RESP.
        trap_d = FILTER_M != 0 && !is_m_insn(bus.req_insn);
        state_d = trap_d ? RESP : ISSUE;
      end
      ISSUE: begin
        cyc_d = &cyc_q ? cyc_q : cyc_q + LAT_W'(1);
        if (bus.pcpi_ready) begin
          wr_d = bus.pcpi_wr;
          rd_d = bus.pcpi_wr ? bus.pcpi_rd : '0;
          trap_d = 1'b0;
          state_d = RESP;
        end else if (wd_expired) begin
          trap_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = bus.resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      insn_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q <= '0;
      wr_q <= 1'b0;
      trap_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      state_q <= state_d;
      insn_q <= insn_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      trap_q <= trap_d;
      cyc_q <= cyc_d;
    end
  end
  // Handshake strobes decode straight from the state register, so reset drops them at once.
  assign bus.req_ready = state_q == IDLE;
  assign bus.pcpi_valid = state_q == ISSUE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.pcpi_insn = insn_q;
  assign bus.pcpi_rs1 = rs1_q;
  assign bus.pcpi_rs2 = rs2_q;
  assign bus.resp_wr = wr_q;
  assign bus.resp_rd = rd_q;
  assign bus.resp_trap = trap_q;
  assign bus.resp_cycles = cyc_q;
endmodule

// File: tb/tb_m_pcpi_initiator.sv
// tb_m_pcpi_initiator: directed transactions against an arithmetic model of the PCPI initiator
module tb_m_pcpi_initiator;
  localparam int TO = 16;
  localparam logic [31:0] MUL = 32'h022081B3;
  localparam logic [31:0] DIVU = 32'h0220D1B3;
  localparam logic [31:0] ADD = 32'h002081B3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  m_pcpi_if #(.LAT_W(16)) bus ();
  m_pcpi_initiator #(.TIMEOUT_CYCLES(TO), .FILTER_M(1), .LAT_W(16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic e_req_ready, e_pv, e_rv, e_wr, e_trap;
  logic [31:0] e_insn, e_rs1, e_rs2, e_rd, e_cyc;
  int kc, pv_cnt, lat;
  logic [31:0] last_rd, last_cyc;
  logic last_wr, last_trap;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("req_ready", 32'(bus.req_ready), 32'(e_req_ready));
    chk("pcpi_valid", 32'(bus.pcpi_valid), 32'(e_pv));
    chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
    if (e_pv) begin
      chk("pcpi_insn", bus.pcpi_insn, e_insn);
      chk("pcpi_rs1", bus.pcpi_rs1, e_rs1);
      chk("pcpi_rs2", bus.pcpi_rs2, e_rs2);
    end
    if (e_rv) begin
      chk("resp_wr", 32'(bus.resp_wr), 32'(e_wr));
      chk("resp_rd", bus.resp_rd, e_rd);
      chk("resp_trap", 32'(bus.resp_trap), 32'(e_trap));
      chk("resp_cycles", 32'(bus.resp_cycles), e_cyc);
    end
    if (bus.pcpi_valid) pv_cnt++;
    if (bus.resp_valid) begin
      if (lat < 0) lat = kc;
      last_rd = bus.resp_rd;
      last_wr = bus.resp_wr;
      last_trap = bus.resp_trap;
      last_cyc = 32'(bus.resp_cycles);
    end
  end
  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_insn = '0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.resp_ready = 1'b0;
    bus.pcpi_wr = 1'b0;
    bus.pcpi_rd = '0;
    bus.pcpi_wait = 1'b0;
    bus.pcpi_ready = 1'b0;
  endtask
  // Responder: pcpi_wait high on cycles ws..we (ws=0: never), pcpi_ready on cycle r (0: never),
  // counting ISSUE cycles from 1. Core holds resp_ready low for `hold` response cycles.
  task automatic txn(input logic [31:0] insn, rs1, rs2, input int ws, we, r,
                     input logic wr, input logic [31:0] rd, input int hold);
    int t, fin;
    logic filt, ok;
    filt = !(insn[6:0] == 7'h33 && insn[31:25] == 7'h01);
    t = (ws == 0 || ws - 1 >= TO) ? TO : 1 << 30;
    ok = !filt && r > 0 && r <= t;
    fin = filt ? 0 : (ok ? r : t);
    e_insn = insn;
    e_rs1 = rs1;
    e_rs2 = rs2;
    e_trap = !ok;
    e_wr = ok && wr;
    e_rd = (ok && wr) ? rd : 32'h0;
    e_cyc = 32'(fin);
    pv_cnt = 0;
    lat = -1;
    kc = 0;
    bus.req_valid = 1'b1;
    bus.req_insn = insn;
    bus.req_rs1 = rs1;
    bus.req_rs2 = rs2;
    e_req_ready = 1'b1;
    e_pv = 1'b0;
    e_rv = 1'b0;
    for (int k = 1; k <= fin + 1 + hold; k++) begin
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_insn = 32'hFFFF_FFFF;
      kc = k;
      bus.pcpi_wait = ws > 0 && k >= ws && k <= we;
      bus.pcpi_ready = k == r;
      bus.pcpi_wr = wr;
      bus.pcpi_rd = rd;
      bus.resp_ready = k == fin + 1 + hold;
      e_req_ready = 1'b0;
      e_pv = k <= fin;
      e_rv = k > fin;
    end
    @(posedge clk);
    #1;
    idle_inputs();
    e_req_ready = 1'b1;
    e_pv = 1'b0;
    e_rv = 1'b0;
  endtask
  initial begin
    idle_inputs();
    #2 reset = 1'b1;
    #2;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rd", bus.resp_rd, 32'd0);
    chk("rst_resp_cycles", 32'(bus.resp_cycles), 32'd0);
    chk("rst_pcpi_insn", bus.pcpi_insn, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    e_req_ready = 1'b1;
    e_pv = 1'b0;
    e_rv = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    txn(MUL, 7, 6, 0, 0, 3, 1'b1, 42, 0);
    chk("mul_rd", last_rd, 32'd42);
    chk("mul_wr", 32'(last_wr), 32'd1);
    chk("mul_trap", 32'(last_trap), 32'd0);
    chk("mul_cycles", last_cyc, 32'd3);
    chk("mul_pv_cnt", 32'(pv_cnt), 32'd3);
    chk("mul_latency", 32'(lat), 32'd4);
    txn(DIVU, 100, 7, 1, 34, 35, 1'b1, 14, 0);
    chk("divu_rd", last_rd, 32'd14);
    chk("divu_trap", 32'(last_trap), 32'd0);
    chk("divu_cycles", last_cyc, 32'd35);
    txn(MUL, 3, 5, 0, 0, 0, 1'b1, 32'hDEAD, 0);
    chk("to_trap", 32'(last_trap), 32'd1);
    chk("to_wr", 32'(last_wr), 32'd0);
    chk("to_rd", last_rd, 32'd0);
    chk("to_cycles", last_cyc, 32'd16);
    chk("to_pv_cnt", 32'(pv_cnt), 32'd16);
    txn(ADD, 1, 2, 0, 0, 1, 1'b1, 3, 0);
    chk("filt_trap", 32'(last_trap), 32'd1);
    chk("filt_pv_cnt", 32'(pv_cnt), 32'd0);
    chk("filt_latency", 32'(lat), 32'd1);
    chk("filt_cycles", last_cyc, 32'd0);
    txn(MUL, 32'h11, 32'h22, 0, 0, 1, 1'b1, 32'h1234, 5);
    chk("hold_rd", last_rd, 32'h1234);
    txn(MUL, 32'h33, 32'h44, 0, 0, 2, 1'b0, 32'h5555, 0);
    chk("nowr_rd", last_rd, 32'd0);
    chk("nowr_wr", 32'(last_wr), 32'd0);
    txn(MUL, 9, 9, 0, 0, 16, 1'b1, 32'h77, 0);
    chk("tie_trap", 32'(last_trap), 32'd0);
    chk("tie_rd", last_rd, 32'h77);
    txn(MUL, 1, 1, 0, 0, 20, 1'b1, 32'hBEEF, 6);
    chk("late_rdy_trap", 32'(last_trap), 32'd1);
    chk("late_rdy_rd", last_rd, 32'd0);
    txn(MUL, 2, 2, 2, 3, 40, 1'b1, 32'h40, 0);
    chk("rearm_trap", 32'(last_trap), 32'd0);
    chk("rearm_cycles", last_cyc, 32'd40);
    txn(MUL, 4, 4, 16, 16, 30, 1'b1, 32'h30, 0);
    chk("wait16_trap", 32'(last_trap), 32'd0);
    txn(MUL, 5, 5, 17, 20, 30, 1'b1, 32'h31, 0);
    chk("wait17_trap", 32'(last_trap), 32'd1);
    e_insn = MUL;
    e_rs1 = 32'd8;
    e_rs2 = 32'd8;
    bus.req_valid = 1'b1;
    bus.req_insn = MUL;
    bus.req_rs1 = 32'd8;
    bus.req_rs2 = 32'd8;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    e_req_ready = 1'b0;
    e_pv = 1'b1;
    @(posedge clk);
    #2;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr = 1'b1;
    bus.pcpi_rd = 32'd99;
    e_req_ready = 1'b1;
    e_pv = 1'b0;
    e_rv = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle_inputs();
    txn(MUL, 6, 7, 0, 0, 1, 1'b1, 32'd42, 0);
    chk("post_rst_rd", last_rd, 32'd42);
    chk("post_rst_cycles", last_cyc, 32'd1);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
